// File: rtl/toggle_port_ram.sv
// Two-port toggle-handshake RAM front end.
// Each port raises a request by making req differ from ack; a single FSM grants
// one port at a time (port 1 has priority), waits WAIT_STATES cycles, then does
// one read or one byte-masked write and toggles that port's ack.
module toggle_port_ram #(
    parameter int AW          = 15,
    parameter int WAIT_STATES = 2
) (
    input  logic          clk,
    input  logic          init_n,
    input  logic          port1_req,
    output logic          port1_ack,
    input  logic [AW-1:0] port1_a,
    input  logic [1:0]    port1_ds,
    input  logic          port1_we,
    input  logic [15:0]   port1_d,
    output logic [15:0]   port1_q,
    input  logic          port2_req,
    output logic          port2_ack,
    input  logic [AW-1:0] port2_a,
    input  logic [1:0]    port2_ds,
    input  logic          port2_we,
    input  logic [15:0]   port2_d,
    output logic [15:0]   port2_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic [1:0]    grant_q;   // one-hot: [0] port 1, [1] port 2
    logic [AW-1:0] addr_q;
    logic [1:0]    ds_q;
    logic          we_q;
    logic [15:0]   d_q;

    // Storage has no reset so it maps onto block RAM and survives init_n.
    logic [15:0]   mem [0:(1<<AW)-1];
    logic [15:0]   rd_data;

    logic          pend1;
    logic          pend2;
    logic          mem_wr;

    assign pend1   = port1_req ^ port1_ack;
    assign pend2   = port2_req ^ port2_ack;
    assign rd_data = mem[addr_q];
    // Only DONE touches the array; reset forces IDLE, so an aborted op never writes.
    assign mem_wr  = (state_q == DONE) && we_q;

    // Arbitration, wait counting, and registered ack/q outputs.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            grant_q   <= 2'b00;
            addr_q    <= '0;
            ds_q      <= 2'b00;
            we_q      <= 1'b0;
            d_q       <= 16'h0000;
            port1_ack <= 1'b0;
            port2_ack <= 1'b0;
            port1_q   <= 16'h0000;
            port2_q   <= 16'h0000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend1) begin
                        addr_q  <= port1_a;
                        ds_q    <= port1_ds;
                        we_q    <= port1_we;
                        d_q     <= port1_d;
                        grant_q <= 2'b01;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= WAIT;
                    end else if (pend2) begin
                        addr_q  <= port2_a;
                        ds_q    <= port2_ds;
                        we_q    <= port2_we;
                        d_q     <= port2_d;
                        grant_q <= 2'b10;
                        cnt_q   <= 4'(WAIT_STATES);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (grant_q[0]) begin
                        port1_ack <= ~port1_ack;
                        if (!we_q) port1_q <= rd_data;
                    end
                    if (grant_q[1]) begin
                        port2_ack <= ~port2_ack;
                        if (!we_q) port2_q <= rd_data;
                    end
                    grant_q <= 2'b00;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Byte-masked write port of the storage array.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            if (ds_q[0]) mem[addr_q][7:0]  <= d_q[7:0];
            if (ds_q[1]) mem[addr_q][15:8] <= d_q[15:8];
        end
    end

endmodule

// File: tb/tb_toggle_port_ram.sv
// Bench for toggle_port_ram: three instances (WAIT_STATES 2, 0, 15) driven by
// directed vectors; expected acks are queued at issue time and a monitor pops
// and checks them whenever any ack toggles.
module tb_toggle_port_ram;

    localparam int AW = 15;
    localparam int ND = 3;

    function automatic int wsv(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 0 : 15);
    endfunction

    typedef struct {
        int          dn;
        int          p;
        int          cyc;
        logic [15:0] q1;
        logic [15:0] q2;
    } exp_t;

    logic          clk;
    logic          init_n;
    logic          req [ND][2];
    logic          ack [ND][2];
    logic [AW-1:0] a   [ND][2];
    logic [1:0]    ds  [ND][2];
    logic          we  [ND][2];
    logic [15:0]   d   [ND][2];
    logic [15:0]   q   [ND][2];

    logic [15:0]   qm   [ND][2];
    logic          prev [ND][2];
    exp_t          sq[$];
    int            cyc;
    int            checks;
    int            errors;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        toggle_port_ram #(.AW(AW), .WAIT_STATES(wsv(g))) u_dut (
            .clk      (clk),
            .init_n   (init_n),
            .port1_req(req[g][0]),
            .port1_ack(ack[g][0]),
            .port1_a  (a[g][0]),
            .port1_ds (ds[g][0]),
            .port1_we (we[g][0]),
            .port1_d  (d[g][0]),
            .port1_q  (q[g][0]),
            .port2_req(req[g][1]),
            .port2_ack(ack[g][1]),
            .port2_a  (a[g][1]),
            .port2_ds (ds[g][1]),
            .port2_we (we[g][1]),
            .port2_d  (d[g][1]),
            .port2_q  (q[g][1])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: any ack toggle must match the head of the expectation queue.
    always @(posedge clk) begin
        #2;
        for (int di = 0; di < ND; di++) begin
            for (int pi = 0; pi < 2; pi++) begin
                if (!init_n) begin
                    prev[di][pi] = ack[di][pi];
                end else if (ack[di][pi] !== prev[di][pi]) begin
                    prev[di][pi] = ack[di][pi];
                    checks++;
                    if (sq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_ack dut%0d port%0d at cycle %0d", di, pi + 1, cyc);
                    end else begin
                        exp_t e;
                        e = sq.pop_front();
                        if (e.dn != di || e.p != pi || e.cyc != cyc ||
                            q[di][0] !== e.q1 || q[di][1] !== e.q2) begin
                            errors++;
                            $display("FAIL ack_check got dut%0d port%0d cyc %0d q1 %h q2 %h, want dut%0d port%0d cyc %0d q1 %h q2 %h",
                                     di, pi + 1, cyc, q[di][0], q[di][1],
                                     e.dn, e.p + 1, e.cyc, e.q1, e.q2);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int dn, input int p, input int ecyc);
        exp_t e;
        e.dn  = dn;
        e.p   = p;
        e.cyc = ecyc;
        e.q1  = qm[dn][0];
        e.q2  = qm[dn][1];
        sq.push_back(e);
    endtask

    // Called at a negedge; the request is sampled at the next rising edge.
    task automatic issue(input int dn, input int p, input logic w, input logic [AW-1:0] ad,
                         input logic [1:0] s, input logic [15:0] wd, input logic [15:0] exp_rd,
                         input int extra, input bit track);
        a[dn][p]   = ad;
        ds[dn][p]  = s;
        we[dn][p]  = w;
        d[dn][p]   = wd;
        req[dn][p] = ~req[dn][p];
        if (track) begin
            if (!w) qm[dn][p] = exp_rd;
            push_exp(dn, p, cyc + 1 + 2 + wsv(dn) + extra);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout %0d acks still outstanding", sq.size());
            sq.delete();
        end
    endtask

    task automatic op(input int dn, input int p, input logic w, input logic [AW-1:0] ad,
                      input logic [1:0] s, input logic [15:0] wd, input logic [15:0] exp_rd);
        issue(dn, p, w, ad, s, wd, exp_rd, 0, 1'b1);
        wait_done();
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        init_n = 1'b0;
        for (int di = 0; di < ND; di++) begin
            for (int pi = 0; pi < 2; pi++) begin
                req[di][pi]  = 1'b0;
                a[di][pi]    = '0;
                ds[di][pi]   = 2'b00;
                we[di][pi]   = 1'b0;
                d[di][pi]    = 16'h0;
                qm[di][pi]   = 16'h0;
                prev[di][pi] = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        for (int di = 0; di < ND; di++) begin
            chk($sformatf("rst_ack1_dut%0d", di), {15'd0, ack[di][0]}, 16'h0);
            chk($sformatf("rst_ack2_dut%0d", di), {15'd0, ack[di][1]}, 16'h0);
            chk($sformatf("rst_q1_dut%0d", di), q[di][0], 16'h0);
            chk($sformatf("rst_q2_dut%0d", di), q[di][1], 16'h0);
        end
        init_n = 1'b1;
        @(negedge clk);

        // Write then read, WAIT_STATES=2 (ack 4 cycles after req).
        op(0, 0, 1'b1, 15'h0010, 2'b11, 16'hBEEF, 16'h0);
        op(0, 0, 1'b0, 15'h0010, 2'b11, 16'h0000, 16'hBEEF);

        // Byte mask, including a ds=00 write that must still ack.
        op(0, 0, 1'b1, 15'h0020, 2'b11, 16'h1234, 16'h0);
        op(0, 0, 1'b1, 15'h0020, 2'b10, 16'hAB00, 16'h0);
        op(0, 1, 1'b0, 15'h0020, 2'b11, 16'h0000, 16'hAB34);
        op(0, 0, 1'b1, 15'h0020, 2'b00, 16'hFFFF, 16'h0);
        op(0, 1, 1'b0, 15'h0020, 2'b11, 16'h0000, 16'hAB34);

        // Collision: port 2 follows port 1 by 3+WAIT_STATES cycles.
        op(0, 1, 1'b1, 15'h0040, 2'b11, 16'h1111, 16'h0);
        issue(0, 0, 1'b0, 15'h0010, 2'b11, 16'h0000, 16'hBEEF, 0, 1'b1);
        issue(0, 1, 1'b0, 15'h0040, 2'b11, 16'h0000, 16'h1111, 3 + wsv(0), 1'b1);
        wait_done();

        // Inputs change after acceptance; latched read of 0x0020 must stand.
        issue(0, 0, 1'b0, 15'h0020, 2'b11, 16'h0000, 16'hAB34, 0, 1'b1);
        @(negedge clk);
        a[0][0]  = 15'h0010;
        we[0][0] = 1'b1;
        d[0][0]  = 16'hDEAD;
        wait_done();
        we[0][0] = 1'b0;
        op(0, 1, 1'b0, 15'h0010, 2'b11, 16'h0000, 16'hBEEF);

        // Latency sweep: WAIT_STATES=0 and 15, including the last word.
        op(1, 0, 1'b1, 15'h0005, 2'b11, 16'h0F0F, 16'h0);
        op(1, 0, 1'b0, 15'h0005, 2'b11, 16'h0000, 16'h0F0F);
        op(2, 1, 1'b1, 15'h7FFF, 2'b11, 16'hC3C3, 16'h0);
        op(2, 1, 1'b0, 15'h7FFF, 2'b11, 16'h0000, 16'hC3C3);

        // Reset during WAIT of a write aborts it.
        op(0, 0, 1'b1, 15'h0030, 2'b11, 16'h0000, 16'h0);
        issue(0, 0, 1'b1, 15'h0030, 2'b11, 16'h5555, 16'h0, 0, 1'b0);
        repeat (2) @(negedge clk);
        init_n = 1'b0;
        for (int di = 0; di < ND; di++) begin
            for (int pi = 0; pi < 2; pi++) begin
                req[di][pi] = 1'b0;
                we[di][pi]  = 1'b0;
                qm[di][pi]  = 16'h0;
            end
        end
        // A port holding req=1 through reset is serviced afterwards.
        a[1][0]   = 15'h0005;
        req[1][0] = 1'b1;
        @(negedge clk);
        chk("midrst_ack1", {15'd0, ack[0][0]}, 16'h0);
        chk("midrst_ack2", {15'd0, ack[0][1]}, 16'h0);
        chk("midrst_q1", q[0][0], 16'h0);
        chk("midrst_q2", q[0][1], 16'h0);
        @(negedge clk);
        init_n = 1'b1;
        qm[1][0] = 16'h0F0F;
        push_exp(1, 0, cyc + 1 + 2 + wsv(1));
        wait_done();
        op(0, 1, 1'b0, 15'h0030, 2'b11, 16'h0000, 16'h0000);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
